// File: rtl/sar_logic.sv
// sar_logic: successive-approximation control for the SAR-ADC model.
// Drives the DAC trial code MSB first and publishes the result with a done pulse.
module sar_logic #(
    parameter int DAC_BITS      = 8,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                comp_in,
    output logic                sample,
    output logic                busy,
    output logic [DAC_BITS-1:0] dac_code,
    output logic [DAC_BITS-1:0] data_out,
    output logic                done
);

    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int IW = $clog2(DAC_BITS);

    localparam logic [CW-1:0]       CNT_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [IW-1:0]       IDX_MSB  = IW'(DAC_BITS - 1);
    localparam logic [DAC_BITS-1:0] MID_CODE = {1'b1, {(DAC_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    // Conversion sequencer; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dac_code <= '0;
            data_out <= '0;
            cnt      <= '0;
            idx      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    dac_code <= '0;
                    if (start) begin
                        state  <= S_SAMPLE;
                        sample <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                    end
                end
                S_SAMPLE: begin
                    dac_code <= '0;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state    <= S_CONVERT;
                        sample   <= 1'b0;
                        idx      <= IDX_MSB;
                        dac_code <= MID_CODE;
                    end
                end
                S_CONVERT: begin
                    dac_code[idx] <= comp_in;
                    if (idx != '0) begin
                        dac_code[idx - 1'b1] <= 1'b1;
                        idx                  <= idx - 1'b1;
                    end else begin
                        state    <= S_DONE;
                        data_out <= {dac_code[DAC_BITS-1:1], comp_in};
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                S_DONE: begin
                    dac_code <= '0;
                    if (start) begin
                        state  <= S_SAMPLE;
                        sample <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
